// File: rtl/sp_if_order_fetch_if.sv
// Order fetch bundle: run control, order memory read port and
// the valid/ready order stream towards the decoder.
interface sp_if_order_fetch_if #(
    parameter int ADR_W  = 10,
    parameter int DATA_W = 32
);
    logic              i_start;
    logic              i_stop;
    logic              i_loop;
    logic [ADR_W-1:0]  i_start_adr;
    logic [ADR_W-1:0]  i_end_adr;
    logic [ADR_W-1:0]  o_mem_rd_adr;
    logic              o_mem_rden;
    logic [DATA_W-1:0] i_mem_rd_data;
    logic [DATA_W-1:0] o_order_data;
    logic              o_order_valid;
    logic              i_order_ready;
    logic              o_busy;
    logic              o_done;
    logic              o_err;

    modport slave (
        input  i_start,
        input  i_stop,
        input  i_loop,
        input  i_start_adr,
        input  i_end_adr,
        input  i_mem_rd_data,
        input  i_order_ready,
        output o_mem_rd_adr,
        output o_mem_rden,
        output o_order_data,
        output o_order_valid,
        output o_busy,
        output o_done,
        output o_err
    );

    modport master (
        output i_start,
        output i_stop,
        output i_loop,
        output i_start_adr,
        output i_end_adr,
        output i_mem_rd_data,
        output i_order_ready,
        input  o_mem_rd_adr,
        input  o_mem_rden,
        input  o_order_data,
        input  o_order_valid,
        input  o_busy,
        input  o_done,
        input  o_err
    );
endinterface

// File: rtl/sp_if_order_fetch.sv
// Order fetch engine: streams a programmable address window from a
// synchronous order memory through a credit-checked order FIFO.
module sp_if_order_fetch #(
    parameter int ADR_W      = 10,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               i_clk156m,
    input  logic               i_arst,
    sp_if_order_fetch_if.slave bus
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int SUM_W = AW + 4;
    localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(FIFO_DEPTH);
    localparam logic [AW:0]      FULL_C  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]      ONE_C   = (AW+1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_e;

    state_e            state_q, state_d;
    logic [ADR_W-1:0]  ptr_q, ptr_d;
    logic [ADR_W-1:0]  first_q, first_d;
    logic [ADR_W-1:0]  last_q, last_d;
    logic              loop_q, loop_d;
    logic              rden_q, rden_d;
    logic [ADR_W-1:0]  rd_adr_q, rd_adr_d;
    logic [RD_LAT-1:0] lat_q, lat_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       cnt_q, cnt_d;

    logic              wr;
    logic              pop;
    logic              full;
    logic              empty;
    logic [SUM_W-1:0]  inflight;
    logic [SUM_W-1:0]  used;

    logic              go;
    logic              lp;
    logic [ADR_W-1:0]  cur;
    logic [ADR_W-1:0]  first;
    logic [ADR_W-1:0]  last;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == FULL_C);
    assign pop   = !empty && bus.i_order_ready;
    assign wr    = lat_q[RD_LAT-1] && !full;
    assign cnt_d = cnt_q + (AW+1)'(wr) - (AW+1)'(pop);

    // Reads still owed to the FIFO: the one on the bus plus the latency pipe.
    always_comb begin
        inflight = SUM_W'(rden_q);
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + SUM_W'(lat_q[i]);
        end
    end

    assign used = inflight + SUM_W'(cnt_q);

    always_comb begin
        lat_d    = '0;
        lat_d[0] = rden_q;
        for (int i = 1; i < RD_LAT; i++) begin
            lat_d[i] = lat_q[i-1];
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        first_d  = first_q;
        last_d   = last_q;
        loop_d   = loop_q;
        rden_d   = 1'b0;
        rd_adr_d = rd_adr_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        go       = 1'b0;
        cur      = ptr_q;
        first    = first_q;
        last     = last_q;
        lp       = loop_q;

        unique case (state_q)
            IDLE: begin
                if (bus.i_start && !bus.i_stop) begin
                    go      = 1'b1;
                    cur     = bus.i_start_adr;
                    first   = bus.i_start_adr;
                    last    = bus.i_end_adr;
                    lp      = bus.i_loop;
                    first_d = bus.i_start_adr;
                    last_d  = bus.i_end_adr;
                    loop_d  = bus.i_loop;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                err_d = bus.i_start;
                if (bus.i_stop) begin
                    state_d = DRAIN;
                end else begin
                    go = (used < DEPTH_S);
                end
            end
            DRAIN: begin
                err_d = bus.i_start;
                if (inflight == '0 &&
                    (empty || (cnt_q == ONE_C && pop))) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The start cycle issues start_adr itself, so the pointer
        // always holds the address after the one just issued.
        if (go) begin
            rden_d   = 1'b1;
            rd_adr_d = cur;
            if (cur != last) begin
                ptr_d = cur + 1'b1;
            end else if (lp) begin
                ptr_d = first;
            end else begin
                ptr_d   = cur;
                state_d = DRAIN;
            end
        end
    end

    always_ff @(posedge i_clk156m or posedge i_arst) begin
        if (i_arst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            first_q  <= '0;
            last_q   <= '0;
            loop_q   <= 1'b0;
            rden_q   <= 1'b0;
            rd_adr_q <= '0;
            lat_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            first_q  <= first_d;
            last_q   <= last_d;
            loop_q   <= loop_d;
            rden_q   <= rden_d;
            rd_adr_q <= rd_adr_d;
            lat_q    <= lat_d;
            done_q   <= done_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            if (wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk156m) begin
        if (wr) begin
            mem_q[wr_ptr_q] <= bus.i_mem_rd_data;
        end
    end

    assign bus.o_mem_rd_adr  = rd_adr_q;
    assign bus.o_mem_rden    = rden_q;
    assign bus.o_order_valid = !empty;
    assign bus.o_order_data  = empty ? '0 : mem_q[rd_ptr_q];
    assign bus.o_busy        = (state_q != IDLE);
    assign bus.o_done        = done_q;
    assign bus.o_err         = err_q;
endmodule

// File: tb/tb_sp_if_order_fetch.sv
// Bench for sp_if_order_fetch: directed scenarios plus randomized runs,
// all checked cycle by cycle against a queue-based reference model.
module tb_sp_if_order_fetch;
    localparam int ADR_W      = 10;
    localparam int DATA_W     = 32;
    localparam int RD_LAT     = 2;
    localparam int FIFO_DEPTH = 8;
    localparam int AMASK      = (1 << ADR_W) - 1;
    localparam int EW         = DATA_W - ADR_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sp_if_order_fetch_if #(.ADR_W(ADR_W), .DATA_W(DATA_W)) bus ();

    sp_if_order_fetch #(
        .ADR_W(ADR_W),
        .DATA_W(DATA_W),
        .RD_LAT(RD_LAT),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .i_clk156m(clk),
        .i_arst(rst),
        .bus(bus)
    );

    // Memory word = {epoch tag, address}; epoch 0 returns the address.
    logic [EW-1:0]     epoch = '0;
    logic [DATA_W-1:0] pipe [RD_LAT];

    function automatic logic [DATA_W-1:0] mdata(input logic [EW-1:0] e,
                                                input logic [ADR_W-1:0] a);
        return {e, a};
    endfunction

    always @(posedge clk) begin
        pipe[0] <= bus.o_mem_rden ? mdata(epoch, bus.o_mem_rd_adr)
                                  : DATA_W'($urandom);
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.i_mem_rd_data = pipe[RD_LAT-1];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Reference model: outstanding = issued - popped; a word read in
    // cycle C becomes poppable in cycle C+RD_LAT+1.
    typedef struct {
        int                avail;
        logic [DATA_W-1:0] data;
    } word_t;

    word_t            q[$];
    int               phase;
    int               issued, popped, outst, occ, k, wlen;
    logic [ADR_W-1:0] wbase;
    bit               wloop;
    bit               e_rden, e_busy, e_done, e_err, ev;
    logic [ADR_W-1:0] e_adr;
    bit               n_rden, n_done, n_errp, do_issue;
    logic [ADR_W-1:0] n_adr;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_rden", bus.o_mem_rden, 0);
            chk("rst_adr", bus.o_mem_rd_adr, 0);
            chk("rst_valid", bus.o_order_valid, 0);
            chk("rst_data", bus.o_order_data, 0);
            chk("rst_busy", bus.o_busy, 0);
            chk("rst_done", bus.o_done, 0);
            chk("rst_err", bus.o_err, 0);
            q.delete();
            issued = 0; popped = 0; phase = 0;
            e_rden = 0; e_adr = '0; e_busy = 0; e_done = 0; e_err = 0;
        end else begin
            ev = (q.size() > 0) && (q[0].avail <= cyc);
            chk("rden", bus.o_mem_rden, e_rden);
            if (e_rden) chk("rd_adr", bus.o_mem_rd_adr, e_adr);
            chk("valid", bus.o_order_valid, ev);
            if (ev) chk("data", bus.o_order_data, q[0].data);
            chk("busy", bus.o_busy, e_busy);
            chk("done", bus.o_done, e_done);
            chk("err", bus.o_err, e_err);
            occ = 0;
            foreach (q[i]) if (q[i].avail <= cyc) occ++;
            chk("fifo_bound", occ <= FIFO_DEPTH, 1);

            if (e_rden) begin
                q.push_back('{avail: cyc + RD_LAT + 1,
                              data: mdata(epoch, e_adr)});
                issued++;
            end
            outst = issued - popped;
            if (ev && bus.i_order_ready) begin
                void'(q.pop_front());
                popped++;
            end

            n_rden = 0; n_adr = e_adr; n_done = 0; n_errp = 0;
            do_issue = 0;
            if (phase == 0) begin
                if (bus.i_start && !bus.i_stop) begin
                    wbase = bus.i_start_adr;
                    wloop = bus.i_loop;
                    wlen  = ((int'(bus.i_end_adr) - int'(bus.i_start_adr))
                             & AMASK) + 1;
                    k = 0; phase = 1; do_issue = 1;
                end
            end else begin
                n_errp = bus.i_start;
                if (phase == 1) begin
                    if (bus.i_stop) phase = 2;
                    else if (outst < FIFO_DEPTH) do_issue = 1;
                end else if (issued == popped) begin
                    phase = 0; n_done = 1;
                end
            end
            if (do_issue) begin
                n_rden = 1;
                n_adr  = ADR_W'((int'(wbase) + (k % wlen)) & AMASK);
                k++;
                if (!wloop && k == wlen) phase = 2;
            end
            e_rden = n_rden; e_adr = n_adr; e_done = n_done;
            e_err = n_errp; e_busy = (phase != 0);
        end
    end

    logic [ADR_W-1:0]  rlog[$];
    logic [DATA_W-1:0] plog[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_mem_rden) rlog.push_back(bus.o_mem_rd_adr);
            if (bus.o_order_valid && bus.i_order_ready)
                plog.push_back(bus.o_order_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [ADR_W-1:0] a,
                         input logic [ADR_W-1:0] b, input bit lp);
        bus.i_start_adr = a;
        bus.i_end_adr   = b;
        bus.i_loop      = lp;
        bus.i_start     = 1'b1;
        tick();
        bus.i_start     = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int n = 0;
        while (bus.o_busy && n < budget) begin
            tick();
            n++;
        end
        chk(nm, n < budget, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int T, cnt, n, stop_at;
    logic [ADR_W-1:0] base;
    int len;

    initial begin
        bus.i_start = 0; bus.i_stop = 0; bus.i_loop = 0;
        bus.i_start_adr = '0; bus.i_end_adr = '0; bus.i_order_ready = 1;
        repeat (3) tick();
        chk("init_busy", bus.o_busy, 0);
        chk("init_valid", bus.o_order_valid, 0);
        rst = 1'b0;
        tick();

        // Single pass 0x010..0x013, literal timing
        T = cyc;
        start(10'h010, 10'h013, 0);
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            if (j == 1) begin
                chk("t1_rden", bus.o_mem_rden, 1);
                chk("t1_adr", bus.o_mem_rd_adr, 10'h010);
                chk("t1_busy", bus.o_busy, 1);
            end
            if (j >= 4 && j <= 7) begin
                chk("t1_valid", bus.o_order_valid, 1);
                chk("t1_data", bus.o_order_data, 32'h010 + j - 4);
            end
            if (j == 8) begin
                chk("t1_done", bus.o_done, 1);
                chk("t1_busy_lo", bus.o_busy, 0);
                chk("t1_cyc", cyc, T + 8);
            end
        end
        tick();

        // Wrap through the top address
        epoch = 1; rlog.delete(); plog.delete();
        start(10'h3FE, 10'h001, 0);
        wait_idle(100, "wrap_timeout");
        tick();
        chk("wrap_n", rlog.size(), 4);
        if (rlog.size() == 4) begin
            chk("wrap_a0", rlog[0], 10'h3FE);
            chk("wrap_a1", rlog[1], 10'h3FF);
            chk("wrap_a2", rlog[2], 10'h000);
            chk("wrap_a3", rlog[3], 10'h001);
        end
        chk("wrap_words", plog.size(), 4);

        // Back-pressure: 20 stalled cycles then drain
        epoch = 2; rlog.delete(); plog.delete();
        bus.i_order_ready = 0;
        start(10'h000, 10'h01F, 0);
        repeat (20) tick();
        chk("bp_stall_rden", rlog.size(), FIFO_DEPTH);
        bus.i_order_ready = 1;
        wait_idle(300, "bp_timeout");
        tick();
        chk("bp_words", plog.size(), 32);
        for (int i = 0; i < plog.size(); i++)
            chk("bp_order", plog[i], mdata(2, ADR_W'(i)));

        // Loop with stop after 7 issued reads
        epoch = 3; rlog.delete(); plog.delete();
        start(10'h005, 10'h006, 1);
        cnt = 0; n = 0;
        while (n < 50) begin
            if (bus.o_mem_rden) cnt++;
            if (cnt == 7) break;
            tick();
            n++;
        end
        chk("loop_reach7", cnt, 7);
        bus.i_stop = 1;
        tick();
        bus.i_stop = 0;
        wait_idle(100, "loop_timeout");
        tick();
        chk("loop_n", rlog.size(), 7);
        for (int i = 0; i < rlog.size(); i++)
            chk("loop_seq", rlog[i], (i % 2) ? 10'h006 : 10'h005);
        chk("loop_words", plog.size(), 7);

        // Start during FETCH -> err; start+stop in IDLE -> ignored
        epoch = 4; rlog.delete(); plog.delete();
        start(10'h100, 10'h10F, 0);
        tick(); tick();
        bus.i_start_adr = 10'h200;
        bus.i_start = 1;
        tick();
        bus.i_start = 0;
        chk("err_pulse", bus.o_err, 1);
        wait_idle(100, "err_timeout");
        tick();
        chk("err_words", plog.size(), 16);
        if (rlog.size() > 0) chk("err_first", rlog[0], 10'h100);
        bus.i_start = 1; bus.i_stop = 1;
        tick();
        bus.i_start = 0; bus.i_stop = 0;
        chk("ss_busy", bus.o_busy, 0);
        chk("ss_rden", bus.o_mem_rden, 0);

        // Asynchronous reset with three reads in flight
        epoch = 5;
        start(10'h200, 10'h27F, 0);
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        chk("ar_rden", bus.o_mem_rden, 0);
        chk("ar_adr", bus.o_mem_rd_adr, 0);
        chk("ar_valid", bus.o_order_valid, 0);
        chk("ar_data", bus.o_order_data, 0);
        chk("ar_busy", bus.o_busy, 0);
        chk("ar_done", bus.o_done, 0);
        chk("ar_err", bus.o_err, 0);
        tick(); tick();
        rst = 1'b0;
        epoch = 6; rlog.delete(); plog.delete();
        start(10'h040, 10'h043, 0);
        wait_idle(100, "ar_timeout");
        tick();
        chk("ar_words", plog.size(), 4);
        for (int i = 0; i < plog.size(); i++)
            chk("ar_word", plog[i], mdata(6, ADR_W'(10'h040 + i)));

        // Randomized windows, readiness, stray starts and stops
        for (int r = 0; r < 12; r++) begin
            epoch = EW'(r + 10);
            base  = ADR_W'($urandom_range(0, AMASK));
            len   = $urandom_range(1, 12);
            start(base, ADR_W'((int'(base) + len - 1) & AMASK),
                  1'($urandom_range(0, 1)));
            stop_at = $urandom_range(3, 40);
            for (int c = 0; c < stop_at; c++) begin
                if (!bus.o_busy) break;
                bus.i_order_ready = ($urandom_range(0, 3) != 0);
                bus.i_start = ($urandom_range(0, 15) == 0);
                tick();
                bus.i_start = 0;
            end
            if (bus.o_busy) begin
                bus.i_stop = 1;
                tick();
                bus.i_stop = 0;
            end
            bus.i_order_ready = 1;
            wait_idle(200, "rnd_timeout");
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
